// File: rtl/spi_tx_scheduler.sv
// spi_tx_scheduler
//   Buffers 16-bit PCM samples from the decimator in a small FIFO and ships
//   them to the MCU as an SPI master (mode 0, MSB first). Each chip-select
//   frame carries one sample. A frame starts only while the MCU is ready.
//
// Optional feature (macro SPI_SEQ_TAG_EN):
//   When defined, every frame is 24 bits: an 8-bit sequence number, then the
//   16-bit sample. The sequence number advances once per completed frame.
//   The MCU can therefore spot dropped samples as gaps in the sequence.
//
// Parameters
//   DEPTH    FIFO entries (power of 2, >= 2)
//   SCK_DIV  clk cycles per sck half-period (>= 1)
//   GAP_CYC  clk cycles cs_n stays high between frames (>= 1)
//
// Ports
//   clk, reset_n   system clock, asynchronous active-low reset
//   audio_valid    single-cycle strobe qualifying pcm_in
//   pcm_in[15:0]   PCM sample
//   mcu_rdy        MCU can take a frame (looked at only in IDLE)
//   clr_ovf        clears the sticky overflow flag
//   sck/cs_n/sdo   SPI master outputs, all registered
//   busy           FSM is not in IDLE
//   fifo_level     current FIFO occupancy
//   overflow       sticky; a sample was dropped because the FIFO was full
module spi_tx_scheduler #(
    parameter int DEPTH   = 8,
    parameter int SCK_DIV = 2,
    parameter int GAP_CYC = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     audio_valid,
    input  logic [15:0]              pcm_in,
    input  logic                     mcu_rdy,
    input  logic                     clr_ovf,
    output logic                     sck,
    output logic                     cs_n,
    output logic                     sdo,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
`ifdef SPI_SEQ_TAG_EN
    localparam int FB = 24;
`else
    localparam int FB = 16;
`endif
    localparam int CMAX = (SCK_DIV > GAP_CYC) ? SCK_DIV : GAP_CYC;
    localparam int CW   = $clog2(CMAX + 1);

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

    state_t          state, state_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic [4:0]      bit_cnt, bit_n;
    logic [FB-1:0]   shift_reg, shift_n;
    logic            sck_n, cs_n_n, sdo_n;
    logic            pop;

    // ---------------- FIFO ----------------
    logic [15:0]     mem [DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic            full, push_ok, drop;
    logic [FB-1:0]   head;

    assign full    = (fifo_level == LW'(DEPTH));
    // A pop in the same cycle frees the slot, so a push while full is still taken.
    assign push_ok = audio_valid && (!full || pop);
    assign drop    = audio_valid && full && !pop;

`ifdef SPI_SEQ_TAG_EN
    logic [7:0] seq;
    assign head = {seq, mem[rd_ptr]};
`else
    assign head = mem[rd_ptr];
`endif

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= pcm_in;
    end

    // Pointers are AW bits wide so they wrap at DEPTH on their own.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            overflow   <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop})
                2'b10:   fifo_level <= fifo_level + 1'b1;
                2'b01:   fifo_level <= fifo_level - 1'b1;
                default: fifo_level <= fifo_level;
            endcase
            // Set wins over clear.
            if (drop)         overflow <= 1'b1;
            else if (clr_ovf) overflow <= 1'b0;
        end
    end

    // ---------------- FSM ----------------
    // Output registers are loaded with the values belonging to the next state,
    // so sck/cs_n/sdo change in the same cycle the state does.
    always_comb begin
        state_n = state;
        cnt_n   = cnt + 1'b1;
        bit_n   = bit_cnt;
        shift_n = shift_reg;
        sck_n   = sck;
        cs_n_n  = cs_n;
        sdo_n   = sdo;
        pop     = 1'b0;
        case (state)
            IDLE: begin
                cnt_n = '0;
                if (fifo_level != '0 && mcu_rdy) begin
                    pop     = 1'b1;
                    shift_n = head;
                    bit_n   = 5'(FB - 1);
                    state_n = SETUP;
                    cs_n_n  = 1'b0;
                    sck_n   = 1'b0;
                    sdo_n   = head[FB-1];
                end
            end
            SETUP: begin
                if (cnt == CW'(SCK_DIV - 1)) begin
                    cnt_n   = '0;
                    sck_n   = 1'b1;
                    state_n = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt == CW'(SCK_DIV - 1)) begin
                    cnt_n = '0;
                    if (sck) begin
                        // Falling edge: present the next bit, except after the
                        // last bit where sdo keeps holding bit 0.
                        sck_n = 1'b0;
                        if (bit_cnt != '0) begin
                            shift_n = {shift_reg[FB-2:0], 1'b0};
                            sdo_n   = shift_reg[FB-2];
                        end
                    end else begin
                        // End of a low phase: next period or done.
                        if (bit_cnt == '0) begin
                            state_n = HOLD;
                        end else begin
                            bit_n = bit_cnt - 1'b1;
                            sck_n = 1'b1;
                        end
                    end
                end
            end
            HOLD: begin
                if (cnt == CW'(SCK_DIV - 1)) begin
                    cnt_n   = '0;
                    cs_n_n  = 1'b1;
                    sdo_n   = 1'b0;
                    state_n = GAP;
                end
            end
            GAP: begin
                if (cnt == CW'(GAP_CYC - 1)) begin
                    cnt_n   = '0;
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
                sck_n   = 1'b0;
                cs_n_n  = 1'b1;
                sdo_n   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
            sck       <= 1'b0;
            cs_n      <= 1'b1;
            sdo       <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            bit_cnt   <= bit_n;
            shift_reg <= shift_n;
            sck       <= sck_n;
            cs_n      <= cs_n_n;
            sdo       <= sdo_n;
            busy      <= (state_n != IDLE);
        end
    end

`ifdef SPI_SEQ_TAG_EN
    // Advances only on completed frames; dropped samples never reach here.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                          seq <= '0;
        else if (state == HOLD && state_n == GAP) seq <= seq + 1'b1;
    end
`endif

endmodule

// File: tb/tb_spi_tx_scheduler.sv
module tb_spi_tx_scheduler;

    localparam int DEPTH   = 8;
    localparam int SCK_DIV = 2;
    localparam int GAP_CYC = 4;
`ifdef SPI_SEQ_TAG_EN
    localparam int FB = 24;
`else
    localparam int FB = 16;
`endif
    localparam int FLEN   = SCK_DIV * (2 * FB + 2);
    localparam int MIN_SP = FLEN + GAP_CYC + 1;

    logic                   clk = 1'b0;
    logic                   reset_n;
    logic                   audio_valid;
    logic [15:0]            pcm_in;
    logic                   mcu_rdy;
    logic                   clr_ovf;
    logic                   sck, cs_n, sdo, busy, overflow;
    logic [$clog2(DEPTH):0] fifo_level;

    spi_tx_scheduler #(.DEPTH(DEPTH), .SCK_DIV(SCK_DIV), .GAP_CYC(GAP_CYC)) dut (
        .clk(clk), .reset_n(reset_n), .audio_valid(audio_valid), .pcm_in(pcm_in),
        .mcu_rdy(mcu_rdy), .clr_ovf(clr_ovf), .sck(sck), .cs_n(cs_n), .sdo(sdo),
        .busy(busy), .fifo_level(fifo_level), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int          nassert = 0;
    int          nfail   = 0;
    int          cyc     = 0;
    int          rises   = 0;
    int          frames_done = 0;
    int          nedge, lowlen, last_start;
    bit          in_frame = 0, have_last = 0, prev_sck = 0, prev_cs = 1;
    logic [FB-1:0] cap;
    logic [FB-1:0] exp_frame;
    logic [7:0]  exp_tag  = 8'h00;
    logic [7:0]  last_tag = 8'h00;
    logic [15:0] sbq[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nassert++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Frame monitor: captures sdo on sck rising edges inside each cs_n frame
    // and checks it against the scoreboard when cs_n rises.
    always @(negedge clk) begin
        cyc++;
        if (!reset_n) begin
            in_frame  = 0;
            have_last = 0;
            prev_sck  = 0;
            prev_cs   = 1;
            exp_tag   = 8'h00;
        end else begin
            if (sck && !prev_sck) begin
                rises++;
                if (in_frame) begin
                    cap = {cap[FB-2:0], sdo};
                    nedge++;
                end
            end
            if (prev_cs && !cs_n) begin
                if (have_last) chk("frame_spacing", 32'(cyc - last_start >= MIN_SP), 32'd1);
                in_frame   = 1;
                have_last  = 1;
                last_start = cyc;
                cap    = '0;
                nedge  = 0;
                lowlen = 0;
            end
            if (!cs_n) lowlen++;
            if (!prev_cs && cs_n && in_frame) begin
                in_frame = 0;
                chk("frame_expected", 32'(sbq.size() != 0), 32'd1);
                if (sbq.size() != 0) begin
`ifdef SPI_SEQ_TAG_EN
                    exp_frame = {exp_tag, sbq.pop_front()};
                    last_tag  = cap[23:16];
`else
                    exp_frame = sbq.pop_front();
`endif
                    chk("frame_bits", 32'(cap), 32'(exp_frame));
                end
                chk("sck_rises", 32'(nedge), 32'(FB));
                chk("cs_low_len", 32'(lowlen), 32'(FLEN));
                exp_tag = exp_tag + 8'd1;
                frames_done++;
            end
            prev_sck = sck;
            prev_cs  = cs_n;
        end
    end

    task automatic push(input logic [15:0] d, input bit expect_tx);
        @(negedge clk);
        audio_valid = 1'b1;
        pcm_in      = d;
        if (expect_tx) sbq.push_back(d);
        @(negedge clk);
        audio_valid = 1'b0;
    endtask

    task automatic wait_frames(input int target);
        int b = 0;
        while (frames_done < target && b < 20000) begin
            @(negedge clk);
            b++;
        end
        chk("frame_wait", 32'(frames_done >= target), 32'd1);
    endtask

    initial begin
        int f0, r0, b;
        reset_n = 1'b0; audio_valid = 1'b0; pcm_in = '0; mcu_rdy = 1'b0; clr_ovf = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_sck", 32'(sck), 32'd0);
        chk("rst_cs_n", 32'(cs_n), 32'd1);
        chk("rst_sdo", 32'(sdo), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_level", 32'(fifo_level), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        reset_n = 1'b1;

        // Single sample, cs_n falls two cycles after the strobe.
        mcu_rdy = 1'b1;
        push(16'hA5C3, 1'b1);
        chk("cs_n_still_high", 32'(cs_n), 32'd1);
        @(negedge clk);
        chk("cs_n_fall", 32'(cs_n), 32'd0);
        chk("busy_in_frame", 32'(busy), 32'd1);
        chk("level_after_pop", 32'(fifo_level), 32'd0);
        wait_frames(1);
        chk("level_end_t1", 32'(fifo_level), 32'd0);

        // Held off by mcu_rdy, then three frames in order.
        mcu_rdy = 1'b0;
        repeat (10) @(negedge clk);
        r0 = rises;
        push(16'h0001, 1'b1);
        push(16'h0002, 1'b1);
        push(16'h0003, 1'b1);
        repeat (20) @(negedge clk);
        chk("no_sck_when_not_rdy", 32'(rises), 32'(r0));
        chk("level_3", 32'(fifo_level), 32'd3);
        f0 = frames_done;
        mcu_rdy = 1'b1;
        wait_frames(f0 + 3);
        chk("level_end_t2", 32'(fifo_level), 32'd0);

        // Overflow: ninth sample is dropped.
        mcu_rdy = 1'b0;
        repeat (10) @(negedge clk);
        for (int i = 0; i < 9; i++) push(16'h0010 + 16'(i), i < 8);
        chk("level_full", 32'(fifo_level), 32'd8);
        chk("ovf_set", 32'(overflow), 32'd1);
        @(negedge clk); clr_ovf = 1'b1;
        @(negedge clk); clr_ovf = 1'b0;
        chk("ovf_cleared", 32'(overflow), 32'd0);

        // Push in the same cycle IDLE pops while full.
        @(negedge clk);
        mcu_rdy = 1'b1; audio_valid = 1'b1; pcm_in = 16'h0099;
        sbq.push_back(16'h0099);
        @(negedge clk);
        audio_valid = 1'b0;
        chk("level_push_pop_full", 32'(fifo_level), 32'd8);
        chk("ovf_push_pop_full", 32'(overflow), 32'd0);
        chk("cs_n_push_pop_full", 32'(cs_n), 32'd0);
        f0 = frames_done;
        wait_frames(f0 + 9);
        chk("sb_empty_t4", 32'(sbq.size()), 32'd0);

        // Reset in the middle of SHIFT.
        push(16'h5A5A, 1'b1);
        push(16'h1234, 1'b1);
        b = 0;
        while (!(in_frame && nedge >= 9) && b < 2000) begin
            @(negedge clk);
            b++;
        end
        chk("reached_mid_shift", 32'(in_frame && nedge >= 9), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_sck", 32'(sck), 32'd0);
        chk("mid_rst_cs_n", 32'(cs_n), 32'd1);
        chk("mid_rst_sdo", 32'(sdo), 32'd0);
        chk("mid_rst_level", 32'(fifo_level), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        sbq.delete();
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        r0 = rises;
        f0 = frames_done;
        repeat (200) @(negedge clk);
        chk("no_resume_sck", 32'(rises), 32'(r0));
        chk("no_resume_frames", 32'(frames_done), 32'(f0));
        chk("no_resume_cs_n", 32'(cs_n), 32'd1);

`ifdef SPI_SEQ_TAG_EN
        // 257 frames: tags 0x00..0xFF then wrap to 0x00.
        f0 = frames_done;
        for (int i = 0; i < 257; i++) begin
            push(16'(i * 37 + 5), 1'b1);
            wait_frames(f0 + i + 1);
        end
        chk("tag_wrap", 32'(last_tag), 32'h00);
        chk("sb_empty_tag", 32'(sbq.size()), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", nassert, nfail);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule

// File: doc/spi_tx_scheduler.md
Name: spi_tx_scheduler

Overview:
- Sits between the PCM decimator output (audio_valid / pcm_in) and the MCU SPI link.
- Buffers 16-bit PCM samples in a small FIFO and acts as SPI master.
- Generates sck, cs_n and sdo (mode 0: CPOL=0, CPHA=0, MSB first) from the single system clock, one sample per chip-select frame.
- Gates frame starts on an MCU ready line and reports occupancy and overflow.

Parameters:
- DEPTH, 8: FIFO entries. Must be a power of 2, ≥2.
- SCK_DIV, 2: clk cycles per sck half-period. Must be ≥1.
- GAP_CYC, 4: clk cycles cs_n is held high between frames. Must be ≥1.

Ports:
- clk  in  1  system clock (1.536 MHz).
- reset_n  in  1  asynchronous active-low reset.
- audio_valid  in  1  single-cycle strobe; pcm_in is valid this cycle.
- pcm_in  in  16  PCM sample.
- mcu_rdy  in  1  MCU can accept a frame; sampled only in IDLE.
- clr_ovf  in  1  clears the overflow flag.
- sck  out  1  SPI clock; idles low.
- cs_n  out  1  chip select, active low.
- sdo  out  1  serial data.
- busy  out  1  high whenever the FSM is not in IDLE.
- fifo_level  out  $clog2(DEPTH)+1  current FIFO occupancy.
- overflow  out  1  sticky; a sample was dropped.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on reset_n.
- Reset values: sck=0, cs_n=1, sdo=0, busy=0, fifo_level=0, overflow=0, FSM=IDLE, FIFO pointers=0.
  - Reset mid-frame aborts immediately; FIFO contents are discarded.
- All outputs are registered; none are driven combinationally from inputs.
- FIFO push:
  - On audio_valid, pcm_in is written if not full.
  - If full and no pop this cycle: sample dropped, overflow set to 1.
  - Push and pop in the same cycle while full: push accepted, level unchanged.
  - Pointers wrap at DEPTH.
- Overflow flag:
  - Stays set until clr_ovf=1.
  - clr_ovf and a new drop in the same cycle: overflow stays 1 (set wins).
- FSM states: IDLE → SETUP → SHIFT → HOLD → GAP → IDLE.
- IDLE:
  - When fifo_level≠0 and mcu_rdy=1, pop the head word into shift_reg and go to SETUP.
  - Next cycle: cs_n=0, sdo=word[15].
  - With an empty FSM, cs_n falls 2 clk cycles after the audio_valid cycle.
- SETUP: lasts SCK_DIV cycles; sck=0, cs_n=0.
- SHIFT: 16 sck periods, each SCK_DIV cycles high then SCK_DIV cycles low.
  - sdo changes only coincident with the sck falling edge, to the next bit (15 down to 0).
  - sdo is stable across every rising edge.
  - Bit counter runs 15..0.
  - After the 16th falling edge, go to HOLD; sdo holds bit 0.
- HOLD: SCK_DIV cycles; sck=0, cs_n=0. Then cs_n=1, sdo=0.
- GAP: GAP_CYC cycles with cs_n=1, then IDLE.
- mcu_rdy is ignored once a frame starts; its deassertion mid-frame does not abort.
- Frame length, cs_n low: SCK_DIV×34 clk cycles (68 at defaults).
- Minimum frame-to-frame spacing: SCK_DIV×34 + GAP_CYC + 1 cycles (73 at defaults).
- fifo_level counts pops at the IDLE→SETUP transition.

Optional Feature:
- Macro: SPI_SEQ_TAG_EN.
- Defined:
  - Each frame is 24 bits: an 8-bit sequence number (MSB first), then the 16-bit sample.
  - The sequence counter resets to 0, increments after each completed frame, and wraps 255→0.
  - SHIFT runs 24 sck periods.
  - cs_n-low length becomes SCK_DIV×50 cycles.
  - Dropped samples do not advance the counter, so the MCU detects loss by sequence jumps.
- Undefined: 16-bit frames exactly as above; no counter logic is present.

Test Plan:
- Reset, mcu_rdy=1, single push of 0xA5C3.
  - Expect cs_n low 2 cycles later and exactly 16 sck rising edges.
  - Bits captured on rising edges = 1010_0101_1100_0011.
  - cs_n high after 68 cycles; fifo_level returns to 0.
- mcu_rdy=0, push 3 samples (0x0001, 0x0002, 0x0003).
  - Expect no sck activity; fifo_level=3.
  - Raise mcu_rdy: three frames in order, spaced ≥73 cycles apart.
- mcu_rdy=0, push 9 samples with DEPTH=8.
  - Expect fifo_level=8 and overflow=1; the 9th sample is never transmitted.
  - Pulse clr_ovf: overflow=0.
- Fill FIFO to 8, then push on the same cycle IDLE pops.
  - Expect level stays 8 and overflow stays 0.
- Assert reset_n=0 mid-SHIFT (after bit 7).
  - Expect immediately sck=0, cs_n=1, sdo=0, fifo_level=0; no partial frame resumes after release.
- With SPI_SEQ_TAG_EN, send 257 frames.
  - Expect tags 0x00..0xFF then 0x00.
  - 24 rising edges per frame; sample bits follow the tag.
